// File: rtl/core_ram_pkg.sv
// Shared types and helpers for the core-bus RAM responder.
// Holds the response record carried through the latency pipe, the grant FSM
// state encoding and the address-decode / parameter-check helpers.
package core_ram_pkg;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  typedef enum logic [0:0] {
    GNT_IDLE,
    GNT_WAIT
  } gnt_state_t;

  function automatic logic is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Compare in 33 bits so a window ending exactly at 2^32 still decodes.
  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [32:0] size);
    logic [32:0] a;
    logic [32:0] b;
    a = {1'b0, addr};
    b = {1'b0, base};
    return (a >= b) && (a < (b + size));
  endfunction

endpackage

// File: rtl/core_if.sv
// Core bus (req/gnt/rvalid) signal bundle.
// slave modport: req/we/be/addr/wdata in, gnt/rvalid/rdata/err out.
// master modport: the mirror image.
interface core_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport slave  (input  req, we, be, addr, wdata,
                  output gnt, rvalid, rdata, err);
  modport master (output req, we, be, addr, wdata,
                  input  gnt, rvalid, rdata, err);
endinterface

// File: rtl/core_ram_resp_pipe.sv
// Response delay line: a valid bit plus resp_t shifted through DEPTH stages.
// Latency: exactly DEPTH cycles from in_vld to out_vld; order preserved.
// Backpressure: none; the upstream outstanding limit keeps it from overrunning.
// Ports: clk, rst_n (async, active low), in_vld/in_resp (captured every edge),
//        out_vld/out_resp (registered, out_resp is zero when out_vld is low).
module core_ram_resp_pipe
  import core_ram_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_vld,
  input  resp_t in_resp,
  output logic  out_vld,
  output resp_t out_resp
);

  logic  vld_q  [DEPTH];
  resp_t resp_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        vld_q[i]  <= 1'b0;
        resp_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= in_vld;
      // Empty slots carry zeros so rdata/err are 0 whenever rvalid is 0.
      resp_q[0] <= in_vld ? in_resp : '0;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_q[i]  <= vld_q[i-1];
        resp_q[i] <= resp_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_resp = resp_q[DEPTH-1];

endmodule

// File: rtl/core_ram_slave.sv
// On-chip RAM responder for the core bus with programmable grant delay,
// response latency (1+WAIT_STATES after grant) and outstanding limit.
// Backpressure: gnt withheld while MAX_OUTSTANDING responses are in flight
// or until req has been held GNT_DELAY cycles; misses answer with err=1.
// Ports: clk, rst_n (async, active low), bus (core_if.slave).
module core_ram_slave
  import core_ram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned SIZE_BYTES      = 65536,
  parameter int unsigned GNT_DELAY       = 0,
  parameter int unsigned WAIT_STATES     = 0,
  parameter int unsigned MAX_OUTSTANDING = 2,
  // Set to 0 for masters that deliberately drop req before gnt.
  parameter bit          MASTER_CHK      = 1'b1
) (
  input logic   clk,
  input logic   rst_n,
  core_if.slave bus
);

  localparam int unsigned WORDS = SIZE_BYTES / 4;
  localparam int IW = (SIZE_BYTES > 4) ? $clog2(SIZE_BYTES) - 2 : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = (GNT_DELAY > 1) ? $clog2(GNT_DELAY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((GNT_DELAY > 0) ? GNT_DELAY - 1 : 0);

  if (!is_pow2(SIZE_BYTES) || SIZE_BYTES < 4) begin : g_bad_size
    $error("core_ram_slave: SIZE_BYTES must be a power of two >= 4");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 8) begin : g_bad_outstanding
    $error("core_ram_slave: MAX_OUTSTANDING must be 1..8");
  end
  if ((64'(BASE_ADDR) + 64'(SIZE_BYTES)) > 64'h1_0000_0000) begin : g_bad_wrap
    $error("core_ram_slave: BASE_ADDR+SIZE_BYTES overflows 32 bits");
  end

  gnt_state_t      state;
  logic [CW-1:0]   cnt;
  logic [OW-1:0]   outstanding;
  logic            can_accept;
  logic            gnt;
  logic            hit;
  logic [IW-1:0]   widx;
  logic            rvalid;
  resp_t           resp_in;
  resp_t           resp_out;
  logic [31:0]     mem [WORDS];

  // No bypass: a response retiring this cycle does not free a slot until next.
  assign can_accept = outstanding < OW'(MAX_OUTSTANDING);
  assign hit        = addr_hit(bus.addr, BASE_ADDR, 33'(SIZE_BYTES));
  assign widx       = IW'((bus.addr - BASE_ADDR) >> 2);

  // gnt must coincide with req, so it is req gated by registered state.
  // Gating with rst_n keeps gnt low for the whole reset, even with req high.
  always_comb begin
    gnt = 1'b0;
    if (rst_n && bus.req && can_accept) begin
      if (GNT_DELAY == 0) gnt = 1'b1;
      else                gnt = (state == GNT_WAIT) && (cnt == '0);
    end
  end

  // Grant delay FSM. The IDLE cycle that sees req counts as the first of the
  // GNT_DELAY cycles, so cnt is preloaded with GNT_DELAY-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GNT_IDLE;
      cnt   <= CNT_LOAD;
    end else if (GNT_DELAY != 0) begin
      case (state)
        GNT_IDLE: begin
          if (bus.req) state <= GNT_WAIT;
          cnt <= CNT_LOAD;
        end
        GNT_WAIT: begin
          if (!bus.req || gnt) begin
            state <= GNT_IDLE;
            cnt   <= CNT_LOAD;
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= GNT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({gnt, rvalid})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // RAM content survives reset; only granted writes that hit touch it.
  always_ff @(posedge clk) begin
    if (gnt && bus.we && hit) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.be[i]) mem[widx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  // Read data is sampled into the pipe at the grant edge; a write granted in
  // an earlier cycle has already landed, so reads always see prior writes.
  always_comb begin
    resp_in = '0;
    if (gnt) begin
      if (!hit)          resp_in.err   = 1'b1;
      else if (!bus.we)  resp_in.rdata = mem[widx];
    end
  end

  core_ram_resp_pipe #(.DEPTH(WAIT_STATES + 1)) u_resp_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (gnt),
    .in_resp  (resp_in),
    .out_vld  (rvalid),
    .out_resp (resp_out)
  );

  assign bus.gnt    = gnt;
  assign bus.rvalid = rvalid;
  assign bus.rdata  = resp_out.rdata;
  assign bus.err    = resp_out.err;

  a_max_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    outstanding <= OW'(MAX_OUTSTANDING));
  // Every rvalid must retire a grant that is still outstanding.
  a_rvalid_matched: assert property (@(posedge clk) disable iff (!rst_n)
    rvalid |-> (outstanding != '0));
  a_no_gnt_in_reset: assert property (@(posedge clk)
    !rst_n |-> !gnt);
  a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (MASTER_CHK && bus.req && !gnt) |=> bus.req);

endmodule

// File: tb/tb_core_ram_slave.sv
module tb_core_ram_slave;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  typedef struct {
    int          k;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int rv_cnt [4];

  logic        req_d [4];
  logic        we_d [4];
  logic [3:0]  be_d [4];
  logic [31:0] addr_d [4];
  logic [31:0] wdata_d [4];
  logic        gnt_o [4];
  logic        rv_o [4];
  logic        er_o [4];
  logic [31:0] rd_o [4];

  exp_t q0[$], q1[$], q2[$], q3[$];

  // 0: defaults, 1: 4 KiB + 2 wait states, 2: grant delay 3, 3: 3 wait states
  core_if bus_if [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_conn
    assign bus_if[g].req   = req_d[g];
    assign bus_if[g].we    = we_d[g];
    assign bus_if[g].be    = be_d[g];
    assign bus_if[g].addr  = addr_d[g];
    assign bus_if[g].wdata = wdata_d[g];
    assign gnt_o[g] = bus_if[g].gnt;
    assign rv_o[g]  = bus_if[g].rvalid;
    assign rd_o[g]  = bus_if[g].rdata;
    assign er_o[g]  = bus_if[g].err;
  end

  core_ram_slave u_a (.clk(clk), .rst_n(rst_n), .bus(bus_if[0]));
  core_ram_slave #(.SIZE_BYTES(4096), .WAIT_STATES(2), .MAX_OUTSTANDING(2))
    u_b (.clk(clk), .rst_n(rst_n), .bus(bus_if[1]));
  core_ram_slave #(.GNT_DELAY(3), .WAIT_STATES(3), .MASTER_CHK(1'b0))
    u_c (.clk(clk), .rst_n(rst_n), .bus(bus_if[2]));
  core_ram_slave #(.WAIT_STATES(3))
    u_d (.clk(clk), .rst_n(rst_n), .bus(bus_if[3]));

  function automatic int ws_of(input int k);
    case (k)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic void q_push(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      2:       q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endfunction

  function automatic int q_size(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      2:       return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic exp_t q_pop(input int k);
    exp_t e;
    case (k)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      2:       e = q2.pop_front();
      default: e = q3.pop_front();
    endcase
    return e;
  endfunction

  function automatic void q_clear_all();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that follows the grant.
  task automatic issue(input int k, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit exp_err, input logic [31:0] exp_rd,
                       output int start_c, output int gnt_c);
    exp_t e;
    bit   got;
    req_d[k] = 1'b1; we_d[k] = we; be_d[k] = be; addr_d[k] = addr; wdata_d[k] = wdata;
    start_c = cyc;
    gnt_c   = -1;
    got     = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (gnt_o[k]) begin
        got     = 1'b1;
        gnt_c   = cyc;
        e.err   = exp_err;
        e.rdata = exp_rd;
        e.due   = cyc + 1 + ws_of(k);
        q_push(k, e);
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL gnt_timeout inst=%0d addr=%h: no gnt in 40 cycles, expected a grant", k, addr);
    end
    @(posedge clk); #1;
    req_d[k] = 1'b0; we_d[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (q_size(k) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q_size(k) != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout inst=%0d: %0d responses missing, expected 0", k, q_size(k));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t tbl [13];
    int   s, g, seen, rv0;
    int   gs [4];

    tbl[0]  = '{0, 1'b1, 4'hF,    32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[1]  = '{0, 1'b0, 4'hF,    32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{0, 1'b1, 4'hF,    32'h0000_0020, 32'h1122_3344, 1'b0, 32'h0};
    tbl[3]  = '{0, 1'b1, 4'b0101, 32'h0000_0020, 32'hAABB_CCDD, 1'b0, 32'h0};
    tbl[4]  = '{0, 1'b0, 4'h0,    32'h0000_0020, 32'h0,         1'b0, 32'h11BB_33DD};
    tbl[5]  = '{0, 1'b1, 4'h0,    32'h0000_0020, 32'hFFFF_FFFF, 1'b0, 32'h0};
    tbl[6]  = '{0, 1'b0, 4'hF,    32'h0000_0023, 32'h0,         1'b0, 32'h11BB_33DD};
    tbl[7]  = '{1, 1'b1, 4'hF,    32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0};
    tbl[8]  = '{1, 1'b1, 4'hF,    32'h0000_0FFC, 32'h0BAD_F00D, 1'b0, 32'h0};
    tbl[9]  = '{1, 1'b0, 4'hF,    32'h0000_1000, 32'h0,         1'b1, 32'h0};
    tbl[10] = '{1, 1'b1, 4'hF,    32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b1, 32'h0};
    tbl[11] = '{1, 1'b0, 4'hF,    32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678};
    tbl[12] = '{1, 1'b0, 4'hF,    32'h0000_0FFE, 32'h0,         1'b0, 32'h0BAD_F00D};

    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_d[k] = 1'b0; we_d[k] = 1'b0; be_d[k] = 4'h0; addr_d[k] = '0; wdata_d[k] = '0;
    end
    req_d[0] = 1'b1;

    // Response monitor: every rvalid is matched in order against the scoreboard.
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
          for (int k = 0; k < 4; k++) begin
            if (rv_o[k]) begin
              rv_cnt[k]++;
              checks++;
              if (q_size(k) == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid inst=%0d cycle=%0d: got rvalid rdata=%h, expected none",
                         k, cyc, rd_o[k]);
              end else begin
                e = q_pop(k);
                if (rd_o[k] !== e.rdata || er_o[k] !== e.err || cyc != e.due)
                  begin
                  errors++;
                  $display("FAIL response inst=%0d: got rdata=%h err=%b cycle=%0d, expected rdata=%h err=%b cycle=%0d",
                           k, rd_o[k], er_o[k], cyc, e.rdata, e.err, e.due);
                end
              end
            end else begin
              checks++;
              if (rd_o[k] !== 32'h0 || er_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL idle_zero inst=%0d: got rdata=%h err=%b, expected 0 0", k, rd_o[k], er_o[k]);
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_gnt%0d", k),    32'(gnt_o[k]), 32'h0);
      chk($sformatf("reset_rvalid%0d", k), 32'(rv_o[k]),  32'h0);
      chk($sformatf("reset_rdata%0d", k),  rd_o[k],       32'h0);
      chk($sformatf("reset_err%0d", k),    32'(er_o[k]),  32'h0);
    end
    req_d[0] = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;

    // Single transactions: defaults, byte lanes, out-of-range on 4 KiB instance.
    for (int i = 0; i < 13; i++) begin
      issue(tbl[i].k, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata,
            tbl[i].exp_err, tbl[i].exp_rd, s, g);
      chk($sformatf("tbl%0d_gnt_same_cycle", i), 32'(g - s), 32'h0);
      drain(tbl[i].k);
    end

    // Outstanding limit: four reads with req held on 2 wait states, limit 2.
    for (int i = 0; i < 4; i++) begin
      issue(1, 1'b1, 4'hF, 32'h40 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0, 32'h0, s, g);
      drain(1);
    end
    for (int i = 0; i < 4; i++)
      issue(1, 1'b0, 4'hF, 32'h40 + 32'(4 * i), 32'h0, 1'b0, 32'hB000_0000 + 32'(i), s, gs[i]);
    chk("limit_gnt1", 32'(gs[1] - gs[0]), 32'd1);
    chk("limit_gnt2_stalled", 32'(gs[2] - gs[0]), 32'd4);
    chk("limit_gnt3", 32'(gs[3] - gs[0]), 32'd5);
    drain(1);

    // Grant delay of 3, then a request abandoned in the wait state.
    issue(2, 1'b1, 4'hF, 32'h80, 32'h5555_AAAA, 1'b0, 32'h0, s, g);
    chk("gdelay_write", 32'(g - s), 32'd3);
    drain(2);
    issue(2, 1'b0, 4'hF, 32'h80, 32'h0, 1'b0, 32'h5555_AAAA, s, g);
    chk("gdelay_read", 32'(g - s), 32'd3);
    drain(2);
    req_d[2] = 1'b1; we_d[2] = 1'b0; addr_d[2] = 32'h80;
    seen = 0;
    @(negedge clk);
    if (gnt_o[2]) seen++;
    @(posedge clk); #1;
    req_d[2] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (gnt_o[2]) seen++;
    end
    chk("abort_no_gnt", 32'(seen), 32'h0);
    @(posedge clk); #1;
    issue(2, 1'b0, 4'hF, 32'h80, 32'h0, 1'b0, 32'h5555_AAAA, s, g);
    chk("gdelay_after_abort", 32'(g - s), 32'd3);
    drain(2);

    // Reset with two reads in flight on the 3-wait-state instance.
    issue(3, 1'b1, 4'hF, 32'h100, 32'hCAFE_F00D, 1'b0, 32'h0, s, g);
    drain(3);
    issue(3, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, 32'hCAFE_F00D, s, gs[0]);
    issue(3, 1'b0, 4'hF, 32'h104, 32'h0, 1'b0, 32'h0, s, gs[1]);
    chk("flight_b2b", 32'(gs[1] - gs[0]), 32'd1);
    req_d[3] = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("midreset_gnt", 32'(gnt_o[3]), 32'h0);
    chk("midreset_rvalid", 32'(rv_o[3]), 32'h0);
    q_clear_all();
    @(posedge clk); #1;
    req_d[3] = 1'b0;
    rst_n    = 1'b1;
    rv0 = rv_cnt[3];
    repeat (10) @(posedge clk);
    #1;
    chk("no_late_rvalid", 32'(rv_cnt[3] - rv0), 32'h0);
    issue(3, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, 32'hCAFE_F00D, s, g);
    drain(3);

    // Reset asserted while rvalid is high must clear outputs without a clock.
    issue(3, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, 32'hCAFE_F00D, s, g);
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      if (rv_o[3]) seen = 1;
    end
    chk("async_rvalid_seen", 32'(seen), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rvalid_clear", 32'(rv_o[3]), 32'h0);
    chk("async_rdata_clear", rd_o[3], 32'h0);
    q_clear_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
